// File: rtl/seg7_scan_reader.sv
// Reader for a multiplexed active-low seven-segment bus. Each stable digit strobe is
// decoded back to BCD, and a full frame of digits is presented on a valid/ready handshake.
module seg7_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              hex,
  input  logic [NUM_DIGITS-1:0]   dig_n,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    valid,
  input  logic                    ready,
  output logic                    err,
  output logic                    ovr
);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  logic [6:0]              hex_meta_reg, hex_sync_reg, hex_prev_reg;
  logic [NUM_DIGITS-1:0]   dig_meta_reg, dig_sync_reg, dig_prev_reg;
  state_t                  state_reg, state_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   strobe, cap_vec, mask_reg;
  logic                    one_hot, changed, frame_done;
  logic [3:0]              dec_val;
  logic                    dec_bad;
  logic [4*NUM_DIGITS-1:0] digits_reg, digits_next;
  logic                    acc_reg;

  // Two-flop synchronizers, preset to the idle bus (blank segments, no strobe)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_meta_reg <= 7'h7F;
      hex_sync_reg <= 7'h7F;
      hex_prev_reg <= 7'h7F;
      dig_meta_reg <= '1;
      dig_sync_reg <= '1;
      dig_prev_reg <= '1;
    end else begin
      hex_meta_reg <= hex;
      hex_sync_reg <= hex_meta_reg;
      hex_prev_reg <= hex_sync_reg;
      dig_meta_reg <= dig_n;
      dig_sync_reg <= dig_meta_reg;
      dig_prev_reg <= dig_sync_reg;
    end
  end

  assign strobe  = ~dig_sync_reg;
  assign one_hot = (strobe != '0) && ((strobe & (strobe - NUM_DIGITS'(1))) == '0);
  assign changed = (hex_sync_reg != hex_prev_reg) || (dig_sync_reg != dig_prev_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    if (!one_hot) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          state_next = SETTLE;
          cnt_next   = 8'd1;
        end
        SETTLE: begin
          state_next = SETTLE;
          cnt_next   = changed ? 8'd1 : cnt_reg + 8'd1;
        end
        HELD: begin
          if (changed) begin
            state_next = SETTLE;
            cnt_next   = 8'd1;
          end
        end
        default: state_next = IDLE;
      endcase
      // Checked on the settle path so a one-cycle stability requirement captures on entry
      if (state_next == SETTLE && cnt_next == STABLE_CNT) begin
        capture    = 1'b1;
        state_next = HELD;
      end
    end
  end

  always_comb begin
    dec_val = 4'hF;
    dec_bad = 1'b0;
    case (hex_sync_reg)
      7'h40:   dec_val = 4'd0;
      7'h79:   dec_val = 4'd1;
      7'h24:   dec_val = 4'd2;
      7'h30:   dec_val = 4'd3;
      7'h19:   dec_val = 4'd4;
      7'h12:   dec_val = 4'd5;
      7'h02:   dec_val = 4'd6;
      7'h78:   dec_val = 4'd7;
      7'h00:   dec_val = 4'd8;
      7'h10:   dec_val = 4'd9;
      default: dec_bad = 1'b1;
    endcase
  end

  assign cap_vec    = capture ? strobe : '0;
  assign frame_done = &mask_reg;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digits_next[4*gi +: 4] = cap_vec[gi] ? dec_val : digits_reg[4*gi +: 4];
    end
  endgenerate

  // A capture landing in the completion cycle seeds the next frame's mask and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_reg <= '0;
      mask_reg   <= '0;
      acc_reg    <= 1'b0;
    end else begin
      digits_reg <= digits_next;
      mask_reg   <= frame_done ? cap_vec : (mask_reg | cap_vec);
      acc_reg    <= frame_done ? (capture & dec_bad) : (acc_reg | (capture & dec_bad));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      ovr <= 1'b0;
      if (frame_done) begin
        if (!valid || ready) begin
          bcd_out <= digits_reg;
          err     <= acc_reg;
          valid   <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
